// File: rtl/ysyx_24100006_wbu_pkg.sv
// Shared encodings for the write-back stage: data-select codes, FSM states
// and the trap cause used by the memory stage.
package ysyx_24100006_defs;
  localparam int XLEN   = 32;
  localparam int GPR_AW = 4;
  localparam int RET_W  = 64;

  typedef enum logic [2:0] {
    GPR_RD_ALU = 3'd0,
    GPR_RD_MEM = 3'd1,
    GPR_RD_PC4 = 3'd2,
    GPR_RD_IMM = 3'd3,
    GPR_RD_CSR = 3'd4
  } gpr_rd_e;

  typedef enum logic [1:0] {
    CSR_RD_RW = 2'd0,
    CSR_RD_RS = 2'd1,
    CSR_RD_RC = 2'd2,
    CSR_RD_RD = 2'd3
  } csr_rd_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_HALT   = 2'd2
  } state_e;

  localparam logic [7:0] MCAUSE_STORE_FAULT = 8'h7;
endpackage

// File: rtl/ysyx_24100006_wbu_if.sv
// Memory-stage -> write-back handshake bundle. The memory stage is the master.
interface ysyx_24100006_wbu_if #(
  parameter int XLEN   = 32,
  parameter int GPR_AW = 4
);
  logic              wb_in_valid;
  logic              wb_in_ready;
  logic [XLEN-1:0]   pc_W;
  logic [XLEN-1:0]   npc_W;
  logic [XLEN-1:0]   alu_result_W;
  logic [XLEN-1:0]   sext_imm_W;
  logic [XLEN-1:0]   rs1_data_W;
  logic [XLEN-1:0]   rdata_csr_W;
  logic [XLEN-1:0]   Mem_rdata_extend;
  logic              is_break_i;
  logic              irq_W;
  logic [7:0]        irq_no_W;
  logic              Gpr_Write_W;
  logic [GPR_AW-1:0] Gpr_Write_Addr_W;
  logic [2:0]        Gpr_Write_RD_W;
  logic              Csr_Write_W;
  logic [11:0]       Csr_Write_Addr_W;
  logic [1:0]        Csr_Write_RD_W;

  modport master (
    output wb_in_valid, pc_W, npc_W, alu_result_W, sext_imm_W, rs1_data_W,
           rdata_csr_W, Mem_rdata_extend, is_break_i, irq_W, irq_no_W,
           Gpr_Write_W, Gpr_Write_Addr_W, Gpr_Write_RD_W,
           Csr_Write_W, Csr_Write_Addr_W, Csr_Write_RD_W,
    input  wb_in_ready
  );

  modport slave (
    input  wb_in_valid, pc_W, npc_W, alu_result_W, sext_imm_W, rs1_data_W,
           rdata_csr_W, Mem_rdata_extend, is_break_i, irq_W, irq_no_W,
           Gpr_Write_W, Gpr_Write_Addr_W, Gpr_Write_RD_W,
           Csr_Write_W, Csr_Write_Addr_W, Csr_Write_RD_W,
    output wb_in_ready
  );
endinterface

// File: rtl/ysyx_24100006_wbu_mux.sv
// Write-back data select for the GPR and CSR write ports.
module ysyx_24100006_wb_mux
  import ysyx_24100006_defs::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_gpr_rd,
  input  logic [1:0]      i_csr_rd,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_alu,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_csr_old,
  input  logic [XLEN-1:0] i_mem,
  output logic [XLEN-1:0] o_gpr_wdata,
  output logic [XLEN-1:0] o_csr_wdata
);
  always_comb begin
    o_gpr_wdata = '0;
    case (i_gpr_rd)
      GPR_RD_ALU: o_gpr_wdata = i_alu;
      GPR_RD_MEM: o_gpr_wdata = i_mem;
      GPR_RD_PC4: o_gpr_wdata = i_pc + XLEN'(4);
      GPR_RD_IMM: o_gpr_wdata = i_imm;
      GPR_RD_CSR: o_gpr_wdata = i_csr_old;
      default:    o_gpr_wdata = '0;
    endcase
  end

  always_comb begin
    o_csr_wdata = i_rs1;
    case (i_csr_rd)
      CSR_RD_RW: o_csr_wdata = i_rs1;
      CSR_RD_RS: o_csr_wdata = i_csr_old | i_rs1;
      CSR_RD_RC: o_csr_wdata = i_csr_old & ~i_rs1;
      CSR_RD_RD: o_csr_wdata = i_csr_old;
      default:   o_csr_wdata = i_rs1;
    endcase
  end
endmodule

// File: rtl/ysyx_24100006_wbu.sv
// Write-back stage: latch on accept, single-cycle commit one cycle later,
// sticky halt on ebreak, retired-instruction counter.
module ysyx_24100006_wbu
  import ysyx_24100006_defs::*;
#(
  parameter int XLEN   = 32,
  parameter int GPR_AW = 4,
  parameter int RET_W  = 64
) (
  input  logic               clk,
  input  logic               reset,
  ysyx_24100006_wbu_if.slave wb,
  output logic               gpr_wen,
  output logic [GPR_AW-1:0]  gpr_waddr,
  output logic [XLEN-1:0]    gpr_wdata,
  output logic               csr_wen,
  output logic [11:0]        csr_waddr,
  output logic [XLEN-1:0]    csr_wdata,
  output logic               trap_wen,
  output logic [XLEN-1:0]    trap_mepc,
  output logic [XLEN-1:0]    trap_mcause,
  output logic               commit_valid,
  output logic [XLEN-1:0]    commit_pc,
  output logic [XLEN-1:0]    commit_npc,
  output logic               halt,
  output logic [RET_W-1:0]   minstret
);
  state_e            r_state;
  logic              r_ready, r_halt;
  logic              r_gpr_wen, r_csr_wen, r_trap_wen, r_commit;
  logic [RET_W-1:0]  r_minstret;
  logic [XLEN-1:0]   r_pc, r_npc, r_alu, r_imm, r_rs1, r_csr_old, r_mem;
  logic              r_brk;
  logic [7:0]        r_irq_no;
  logic [GPR_AW-1:0] r_gaddr;
  logic [2:0]        r_grd;
  logic [11:0]       r_caddr;
  logic [1:0]        r_crd;

  // Strobes are decided at accept time so they leave a flop in the commit cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b1;
      r_halt     <= 1'b0;
      r_gpr_wen  <= 1'b0;
      r_csr_wen  <= 1'b0;
      r_trap_wen <= 1'b0;
      r_commit   <= 1'b0;
      r_minstret <= '0;
      r_pc       <= '0;
      r_npc      <= '0;
      r_alu      <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_csr_old  <= '0;
      r_mem      <= '0;
      r_brk      <= 1'b0;
      r_irq_no   <= '0;
      r_gaddr    <= '0;
      r_grd      <= '0;
      r_caddr    <= '0;
      r_crd      <= '0;
    end else begin
      r_gpr_wen  <= 1'b0;
      r_csr_wen  <= 1'b0;
      r_trap_wen <= 1'b0;
      r_commit   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wb.wb_in_valid && r_ready) begin
            r_pc       <= wb.pc_W;
            r_npc      <= wb.npc_W;
            r_alu      <= wb.alu_result_W;
            r_imm      <= wb.sext_imm_W;
            r_rs1      <= wb.rs1_data_W;
            r_csr_old  <= wb.rdata_csr_W;
            r_mem      <= wb.Mem_rdata_extend;
            r_brk      <= wb.is_break_i;
            r_irq_no   <= wb.irq_no_W;
            r_gaddr    <= wb.Gpr_Write_Addr_W;
            r_grd      <= wb.Gpr_Write_RD_W;
            r_caddr    <= wb.Csr_Write_Addr_W;
            r_crd      <= wb.Csr_Write_RD_W;
            r_gpr_wen  <= wb.Gpr_Write_W & ~wb.irq_W & (|wb.Gpr_Write_Addr_W);
            r_csr_wen  <= wb.Csr_Write_W & ~wb.irq_W;
            r_trap_wen <= wb.irq_W;
            r_commit   <= 1'b1;
            r_minstret <= r_minstret + RET_W'(1);
            r_ready    <= 1'b0;
            r_state    <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          if (r_brk) begin
            r_halt  <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  ysyx_24100006_wb_mux #(.XLEN(XLEN)) u_mux (
    .i_gpr_rd    (r_grd),
    .i_csr_rd    (r_crd),
    .i_pc        (r_pc),
    .i_alu       (r_alu),
    .i_imm       (r_imm),
    .i_rs1       (r_rs1),
    .i_csr_old   (r_csr_old),
    .i_mem       (r_mem),
    .o_gpr_wdata (gpr_wdata),
    .o_csr_wdata (csr_wdata)
  );

  // A reset landing on the commit cycle cancels that commit outright.
  assign gpr_wen      = r_gpr_wen  & ~reset;
  assign csr_wen      = r_csr_wen  & ~reset;
  assign trap_wen     = r_trap_wen & ~reset;
  assign commit_valid = r_commit   & ~reset;

  assign wb.wb_in_ready = r_ready;
  assign gpr_waddr      = r_gaddr;
  assign csr_waddr      = r_caddr;
  assign trap_mepc      = r_pc;
  assign trap_mcause    = {{(XLEN-8){1'b0}}, r_irq_no};
  assign commit_pc      = r_pc;
  assign commit_npc     = r_npc;
  assign halt           = r_halt;
  assign minstret       = r_minstret;
endmodule

// File: doc/ysyx_24100006_wbu.md
Name: ysyx_24100006_wbu

Overview:
Write-back stage, directly downstream of the memory-access stage. It accepts one retiring instruction per valid/ready handshake and captures all fields on the accept edge, because load data is only valid during the handshake cycle. One cycle later it issues a single-cycle commit: GPR write, CSR write or trap-CSR write, plus a retire pulse. It also halts the pipeline on ebreak and keeps the 64-bit retired-instruction counter.

Parameters:
XLEN, 32, datapath width
GPR_AW, 4, GPR address width (16 registers)
RET_W, 64, retired-instruction counter width

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
wb_in_valid  in  1  upstream valid
wb_in_ready  out  1  upstream ready
pc_W  in  XLEN  instruction PC
npc_W  in  XLEN  next PC of the instruction
alu_result_W  in  XLEN  ALU result
sext_imm_W  in  XLEN  sign-extended immediate
rs1_data_W  in  XLEN  rs1 operand
rdata_csr_W  in  XLEN  old CSR value
Mem_rdata_extend  in  XLEN  extended load data; valid only in the handshake cycle
is_break_i  in  1  ebreak
irq_W  in  1  trap request
irq_no_W  in  8  trap cause
Gpr_Write_W  in  1  GPR write enable
Gpr_Write_Addr_W  in  GPR_AW  rd
Gpr_Write_RD_W  in  3  GPR data select
Csr_Write_W  in  1  CSR write enable
Csr_Write_Addr_W  in  12  CSR address
Csr_Write_RD_W  in  2  CSR data select
gpr_wen  out  1  GPR write strobe
gpr_waddr  out  GPR_AW  GPR address
gpr_wdata  out  XLEN  GPR data
csr_wen  out  1  CSR write strobe
csr_waddr  out  12  CSR address
csr_wdata  out  XLEN  CSR data
trap_wen  out  1  trap strobe: write mepc and mcause
trap_mepc  out  XLEN  value for mepc
trap_mcause  out  XLEN  value for mcause
commit_valid  out  1  retire pulse
commit_pc  out  XLEN  retired PC
commit_npc  out  XLEN  retired next PC
halt  out  1  ebreak reached, sticky
minstret  out  RET_W  retired-instruction count

Behaviour:
- States:
  - S_IDLE: wb_in_ready=1. On valid&ready, latch all inputs (including Mem_rdata_extend) and go to S_COMMIT.
  - S_COMMIT: wb_in_ready=0. All strobes are driven from the latched fields for exactly one cycle. Next state is S_HALT if the latched is_break is set, else S_IDLE.
  - S_HALT: wb_in_ready=0. Stay in S_HALT until reset.
- Latency: accept on edge N; strobes are high in cycle N+1. Throughput is one instruction per 2 cycles.
- gpr_wdata select by Gpr_Write_RD:
  - 0: alu_result
  - 1: mem_rdata
  - 2: pc+4
  - 3: sext_imm
  - 4: rdata_csr
  - 5-7: 0
- csr_wdata select by Csr_Write_RD:
  - 0: rs1
  - 1: rdata_csr | rs1
  - 2: rdata_csr & ~rs1
  - 3: rdata_csr
- gpr_wen = S_COMMIT & Gpr_Write & ~irq & (waddr != 0). Writes to x0 are never emitted.
- csr_wen = S_COMMIT & Csr_Write & ~irq.
- Trap commit (irq set):
  - trap_wen = S_COMMIT & irq.
  - trap_mepc = pc; trap_mcause = zero-extended irq_no.
  - GPR and CSR strobes are suppressed.
- commit_valid = S_COMMIT, including trap and ebreak. minstret increments by 1 on each commit_valid and wraps modulo 2^RET_W.
- halt is set in the S_COMMIT cycle of an ebreak and holds until reset.
- Data outputs (addresses, wdata, mepc, mcause, commit_pc/npc) are driven from the latch registers at all times. Strobes are zero outside S_COMMIT.
- Reset values:
  - state = S_IDLE
  - all strobes = 0, halt = 0, minstret = 0
  - latch registers = 0 (so data outputs = 0)
  - wb_in_ready = 1 in the first cycle after reset.
- Reset mid-commit: the pending commit is discarded and no strobe fires.
- Reset while in S_HALT returns the block to S_IDLE.
- wb_in_valid while not ready is ignored. Upstream must hold the instruction until accepted.

Decomposition:
- Shared package ysyx_24100006_defs:
  - GPR_RD_ALU/MEM/PC4/IMM/CSR encodings
  - CSR_RD_RW/RS/RC/RD encodings
  - state encodings
  - mcause store-fault code 8'h7
- Sub-module ysyx_24100006_wb_mux: combinational GPR/CSR data select. Everything else is flat.

Test Plan:
- ALU write: Gpr_Write=1, addr=5, RD=0, alu=0x1234 -> 1 cycle after accept: gpr_wen=1, waddr=5, wdata=0x1234, commit_valid=1, minstret=1.
- Load capture: RD=1, Mem_rdata_extend=0xFFFFFF80 in the handshake cycle only, 0 afterwards -> gpr_wdata=0xFFFFFF80 at commit.
- x0 guard plus CSR set: addr=0, Gpr_Write=1; Csr_Write=1, addr=0x300, RD=1, rdata_csr=0x8, rs1=0x80 -> gpr_wen=0, csr_wen=1, csr_wdata=0x88.
- Trap: irq=1, irq_no=7, pc=0x80000010, Gpr_Write=1 -> trap_wen=1, mepc=0x80000010, mcause=7, gpr_wen=0, commit_valid=1.
- Ebreak: is_break=1 -> commit_valid, then halt=1 and wb_in_ready=0 forever. Further valids are ignored; after reset, ready=1 and halt=0.
- Back-to-back valids held high: accepts occur every 2 cycles; 10 instructions -> minstret=10; a reset asserted in S_COMMIT produces no strobe.
